fwd_hazard_unit: RTL

- Parametrised operand-forwarding and load-use hazard unit for the RV32I 5-stage pipeline (IF/ID/EX/MEM/WB).
- Resolves NUM_RS source operands in ID against EX, MEM and optionally WB producers.
- Owns a load-latency stall FSM so that multi-cycle data memories stall for the correct number of cycles.
- Includes a saturating stall performance counter.

---
 rtl/rv32_pkg.sv | 35 +++
 rtl/fwd_port_mux.sv | 72 +++++++
 rtl/fwd_hazard_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: opcodes, forwarding-source encoding, hazard FSM states
// and the producer classification used by the forwarding logic.
package rv32_pkg;

    localparam logic [6:0] OpRr     = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;

    localparam logic [1:0] FwdReg = 2'd0;
    localparam logic [1:0] FwdEx  = 2'd1;
    localparam logic [1:0] FwdMem = 2'd2;
    localparam logic [1:0] FwdWb  = 2'd3;

    typedef enum logic {
        StIdle,
        StWait
    } hz_state_e;

    // Branch, Store and unknown opcodes never write rd.
    function automatic logic is_writer(input logic [6:0] op);
        logic w;
        case (op)
            OpRr, OpImm, OpLui, OpAuipc, OpJal, OpJalr, OpLoad: w = 1'b1;
            default:                                            w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fwd_port_mux.sv
// Single source-operand forwarding mux: EX > MEM > (WB) > register-file priority.
// WB forwarding is compiled in only when FWD_WB_FWD_EN is defined.
module fwd_port_mux
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic            rs_use,
    input  logic [XLEN-1:0] reg_data,
    input  logic [4:0]      ex_rd,
    input  logic [6:0]      ex_type,
    input  logic [XLEN-1:0] ex_alu,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [4:0]      mem_rd,
    input  logic [6:0]      mem_type,
    input  logic [XLEN-1:0] mem_out,
`ifdef FWD_WB_FWD_EN
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
`endif
    input  logic            in_wait,
    output logic [XLEN-1:0] fwd,
    output logic [1:0]      fwd_sel,
    output logic            load_req
);

    logic rs_valid;
    logic ex_hit;
    logic mem_hit;

    assign rs_valid = rs_use && (rs != 5'd0);
    assign ex_hit   = rs_valid && (rs == ex_rd) && is_writer(ex_type);
    assign mem_hit  = rs_valid && (rs == mem_rd) && is_writer(mem_type);

`ifdef FWD_WB_FWD_EN
    logic wb_hit;
    assign wb_hit = rs_valid && wb_we && (rs == wb_rd);
`endif

    always_comb begin
        fwd      = reg_data;
        fwd_sel  = FwdReg;
        load_req = 1'b0;
        if (ex_hit) begin
            if (ex_type == OpLoad) begin
                // Load data does not exist yet; hold the reg value and request a stall.
                load_req = 1'b1;
            end else if (ex_type == OpJal || ex_type == OpJalr) begin
                fwd     = ex_pc + XLEN'(4);
                fwd_sel = FwdEx;
            end else begin
                fwd     = ex_alu;
                fwd_sel = FwdEx;
            end
        end else if (mem_hit) begin
            // A multi-cycle load still in MEM has no valid data yet.
            if (!(in_wait && mem_type == OpLoad)) begin
                fwd     = mem_out;
                fwd_sel = FwdMem;
            end
        end
`ifdef FWD_WB_FWD_EN
        else if (wb_hit) begin
            fwd     = wb_data;
            fwd_sel = FwdWb;
        end
`endif
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the RV32I 5-stage pipeline.
// Define FWD_WB_FWD_EN to add WB-stage forwarding and the wb_* ports.
module fwd_hazard_unit
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_RS   = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NUM_RS*5-1:0]    id_rs,
    input  logic [NUM_RS-1:0]      id_rs_use,
    input  logic [NUM_RS*XLEN-1:0] id_reg,
    input  logic [4:0]             ex_rd,
    input  logic [6:0]             ex_type,
    input  logic [XLEN-1:0]        ex_alu,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic [4:0]             mem_rd,
    input  logic [6:0]             mem_type,
    input  logic [XLEN-1:0]        mem_out,
`ifdef FWD_WB_FWD_EN
    input  logic [4:0]             wb_rd,
    input  logic                   wb_we,
    input  logic [XLEN-1:0]        wb_data,
`endif
    input  logic                   stall_clr,
    output logic [NUM_RS*XLEN-1:0] fwd,
    output logic [NUM_RS*2-1:0]    fwd_sel,
    output logic                   load_stall,
    output logic [CNT_W-1:0]       stall_cycles
);

    localparam int unsigned LatW = $clog2(LOAD_LAT + 1);

    hz_state_e         state_q, state_d;
    logic [LatW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [NUM_RS-1:0] load_req;
    logic              in_wait;

    assign in_wait = (state_q == StWait);

    for (genvar k = 0; k < NUM_RS; k++) begin : g_port
        fwd_port_mux #(
            .XLEN(XLEN)
        ) u_mux (
            .rs       (id_rs[5*k +: 5]),
            .rs_use   (id_rs_use[k]),
            .reg_data (id_reg[XLEN*k +: XLEN]),
            .ex_rd    (ex_rd),
            .ex_type  (ex_type),
            .ex_alu   (ex_alu),
            .ex_pc    (ex_pc),
            .mem_rd   (mem_rd),
            .mem_type (mem_type),
            .mem_out  (mem_out),
`ifdef FWD_WB_FWD_EN
            .wb_rd    (wb_rd),
            .wb_we    (wb_we),
            .wb_data  (wb_data),
`endif
            .in_wait  (in_wait),
            .fwd      (fwd[XLEN*k +: XLEN]),
            .fwd_sel  (fwd_sel[2*k +: 2]),
            .load_req (load_req[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        load_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                load_stall = |load_req;
                // With single-cycle memory the bubble alone lets MEM forwarding take over.
                if (|load_req && LOAD_LAT > 1) begin
                    state_d    = StWait;
                    wait_cnt_d = LatW'(LOAD_LAT - 1);
                end
            end
            StWait: begin
                load_stall = 1'b1;
                wait_cnt_d = wait_cnt_q - LatW'(1);
                if (wait_cnt_q == LatW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                wait_cnt_d = '0;
            end
        endcase
        if (flush) begin
            load_stall = 1'b0;
            state_d    = StIdle;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_clr) begin
            stall_cnt_q <= '0;
        end else if (load_stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
